// File: rtl/clk_div_mc_pkg.sv
// Shared helpers for the multi-channel clock-enable / divided-waveform generator.
package clk_div_mc_pkg;

  // Channel-index width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Number of counter states for which the divided waveform is high.
  function automatic int unsigned half_thr(input int unsigned d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_mc_ch.sv
// One divider channel: counter, config shadow/pending, registered ce and waveform.
// Phase-on-sync support is compiled in with CLK_DIV_MC_PHASE_EN.
module clk_div_mc_ch
  import clk_div_mc_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
`ifdef CLK_DIV_MC_PHASE_EN
  input  logic [CNT_W-1:0] cfg_phase,
`endif
  input  logic             sync_i,
  output logic             pending,
  output logic             ce,
  output logic             div_wave,
  output logic             active
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
`ifdef CLK_DIV_MC_PHASE_EN
    logic [CNT_W-1:0] phase;
`endif
  } ch_cfg_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_cfg_t          applied_reg, applied_next;
  ch_cfg_t          shadow_reg, shadow_next;
  ch_cfg_t          rst_cfg, cfg_in;
  logic             pending_reg, pending_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] sync_cnt, half_div;
  logic             ce_reg, div_wave_reg;
  logic             tc, apply;

  always_comb begin
    rst_cfg     = '0;
    rst_cfg.div = CNT_W'(DIV_RST);
    cfg_in      = '0;
    cfg_in.div  = cfg_div;
`ifdef CLK_DIV_MC_PHASE_EN
    cfg_in.phase = cfg_phase;
`endif
  end

  assign half_div = CNT_W'(half_thr(32'(applied_reg.div)));

  always_comb begin
    applied_next = applied_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    tc    = (applied_reg.div != '0) && (cnt_reg == applied_reg.div - ONE);
    // A disabled channel has no period boundary, so a pending value lands at once.
    apply = pending_reg && (sync_i || tc || (applied_reg.div == '0));
    if (apply) applied_next = shadow_reg;
    if (cfg_we) begin
      shadow_next  = cfg_in;
      pending_next = 1'b1;
    end else if (apply) begin
      pending_next = 1'b0;
    end

`ifdef CLK_DIV_MC_PHASE_EN
    if (applied_next.div == '0)
      sync_cnt = '0;
    else if (applied_next.phase >= applied_next.div)
      sync_cnt = applied_next.div - ONE;
    else
      sync_cnt = applied_next.phase;
`else
    sync_cnt = '0;
`endif

    if (sync_i)
      cnt_next = sync_cnt;
    else if ((applied_next.div == '0) || tc || (applied_reg.div == '0))
      cnt_next = '0;
    else
      cnt_next = cnt_reg + ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      applied_reg  <= rst_cfg;
      shadow_reg   <= '0;
      pending_reg  <= 1'b0;
      cnt_reg      <= '0;
      ce_reg       <= 1'b0;
      div_wave_reg <= 1'b0;
    end else begin
      applied_reg  <= applied_next;
      shadow_reg   <= shadow_next;
      pending_reg  <= pending_next;
      cnt_reg      <= cnt_next;
      ce_reg       <= tc;
      div_wave_reg <= (applied_reg.div != '0) && (cnt_reg < half_div);
    end
  end

  assign pending  = pending_reg;
  assign ce       = ce_reg;
  assign div_wave = div_wave_reg;
  assign active   = (applied_reg.div != '0);

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock-enable and divided-waveform generator.
// Define CLK_DIV_MC_PHASE_EN to add a per-channel phase loaded on sync.
module clk_div_mc
  import clk_div_mc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2,
  localparam int CH_W   = ch_width(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
`ifdef CLK_DIV_MC_PHASE_EN
  input  logic [CNT_W-1:0] cfg_phase_i,
`endif
  input  logic             sync_i,
  output logic [NCH-1:0]   ce_o,
  output logic [NCH-1:0]   div_o,
  output logic [NCH-1:0]   active_o
);

  logic [NCH-1:0] ch_pending;
  logic [NCH-1:0] ch_we;

  // Out-of-range channel indices stay ready so those requests are swallowed.
  always_comb begin
    cfg_ready_o = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_ch_i == CH_W'(c)) cfg_ready_o = ~ch_pending[c];
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_we[gi] = cfg_valid_i && cfg_ready_o && (cfg_ch_i == CH_W'(gi));

      clk_div_mc_ch #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
      ) u_ch (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cfg_we   (ch_we[gi]),
        .cfg_div  (cfg_div_i),
`ifdef CLK_DIV_MC_PHASE_EN
        .cfg_phase(cfg_phase_i),
`endif
        .sync_i   (sync_i),
        .pending  (ch_pending[gi]),
        .ce       (ce_o[gi]),
        .div_wave (div_o[gi]),
        .active   (active_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_mc.sv
// Directed self-checking bench for clk_div_mc (NCH=4, CNT_W=8, DIV_RST=4).
module tb_clk_div_mc;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic [1:0] cfg_ch_i = 2'd0;
  logic [7:0] cfg_div_i = 8'd0;
  logic       sync_i = 1'b0;
  logic [3:0] ce_o, div_o, active_o;
  logic [3:0] e_ce, e_dv;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk_i = ~clk_i;

  clk_div_mc #(.NCH(4), .CNT_W(8), .DIV_RST(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_div_i  (cfg_div_i),
    .sync_i     (sync_i),
    .ce_o       (ce_o),
    .div_o      (div_o),
    .active_o   (active_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cfg_req(input logic [1:0] ch, input logic [7:0] dv);
    cfg_ch_i    = ch;
    cfg_div_i   = dv;
    cfg_valid_i = 1'b1;
    $display("[TB] cyc %0d cfg request ch%0d div=%0d", cyc, ch, dv);
  endtask

  // Counter is 0 after edge k0; ce is high after edge k when (k-k0) is a multiple of d.
  function automatic logic exp_ce(input int k, input int k0, input int d);
    return (k > k0) && (((k - k0) % d) == 0);
  endfunction

  function automatic logic exp_dv(input int k, input int k0, input int d);
    return (((k - 1 - k0) % d) < (d / 2));
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ce", 32'(ce_o), 32'h0);
    chk("rst_div", 32'(div_o), 32'h0);
    chk("rst_active", 32'(active_o), 32'hF);
    chk("rst_ready", 32'(cfg_ready_o), 32'h1);
    rst_i = 1'b0;

    // All channels at DIV_RST=4
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("p1_ce", 32'({4{exp_ce(cyc, 0, 4)}}), 32'(ce_o));
      chk("p1_div", 32'(div_o), 32'({4{exp_dv(cyc, 0, 4)}}));
    end

    // ch1 -> 3, written mid-period
    step();
    cfg_req(2'd1, 8'd3);
    #1;
    chk("ch1_ready_pre", 32'(cfg_ready_o), 32'h1);
    step();
    cfg_valid_i = 1'b0;
    chk("ch1_ready_held14", 32'(cfg_ready_o), 32'h0);
    chk("ch1_div14", 32'(div_o[1]), 32'h1);
    chk("ch1_ce14", 32'(ce_o[1]), 32'h0);
    step();
    chk("ch1_ready_held15", 32'(cfg_ready_o), 32'h0);
    chk("ch1_div15", 32'(div_o[1]), 32'h0);
    step();
    chk("ch1_ready_applied", 32'(cfg_ready_o), 32'h1);
    chk("ch1_ce16", 32'(ce_o[1]), 32'h1);
    chk("ch1_div16", 32'(div_o[1]), 32'h0);
    for (int k = 17; k <= 22; k++) begin
      step();
      chk("ch1_d3_ce", 32'(ce_o[1]), 32'(exp_ce(cyc, 16, 3)));
      chk("ch1_d3_div", 32'(div_o[1]), 32'(exp_dv(cyc, 16, 3)));
      chk("ch0_d4_ce", 32'(ce_o[0]), 32'(exp_ce(cyc, 0, 4)));
    end

    // ch2 disable, then re-enable with 5
    cfg_req(2'd2, 8'd0);
    step();
    cfg_valid_i = 1'b0;
    chk("ch2_active23", 32'(active_o[2]), 32'h1);
    step();
    chk("ch2_active24", 32'(active_o[2]), 32'h0);
    chk("ch2_ce24", 32'(ce_o[2]), 32'h1);
    step();
    chk("ch2_ce25", 32'(ce_o[2]), 32'h0);
    chk("ch2_div25", 32'(div_o[2]), 32'h0);
    cfg_req(2'd2, 8'd5);
    step();
    cfg_valid_i = 1'b0;
    chk("ch2_active26", 32'(active_o[2]), 32'h0);
    chk("ch2_ready26", 32'(cfg_ready_o), 32'h0);
    step();
    chk("ch2_active27", 32'(active_o[2]), 32'h1);
    chk("ch2_ready27", 32'(cfg_ready_o), 32'h1);
    chk("ch2_ce27", 32'(ce_o[2]), 32'h0);
    for (int k = 28; k <= 32; k++) begin
      step();
      chk("ch2_d5_ce", 32'(ce_o[2]), 32'(exp_ce(cyc, 27, 5)));
      chk("ch2_d5_div", 32'(div_o[2]), 32'(exp_dv(cyc, 27, 5)));
    end

    // Back-to-back writes to ch0, ch3 write accepted in between
    cfg_req(2'd0, 8'd2);
    step();
    cfg_req(2'd0, 8'd6);
    #1;
    chk("ch0_b2b_ready33", 32'(cfg_ready_o), 32'h0);
    cfg_req(2'd3, 8'd7);
    #1;
    chk("ch3_ready33", 32'(cfg_ready_o), 32'h1);
    step();
    cfg_req(2'd0, 8'd6);
    #1;
    chk("ch0_b2b_ready34", 32'(cfg_ready_o), 32'h0);
    step();
    chk("ch0_b2b_ready35", 32'(cfg_ready_o), 32'h0);
    step();
    chk("ch0_b2b_ready36", 32'(cfg_ready_o), 32'h1);
    chk("ch0_ce36", 32'(ce_o[0]), 32'h1);
    chk("ch3_ce36", 32'(ce_o[3]), 32'h1);
    step();
    cfg_valid_i = 1'b0;
    chk("ch0_second_ready37", 32'(cfg_ready_o), 32'h0);
    chk("ch0_d2_ce37", 32'(ce_o[0]), 32'h0);
    chk("ch0_d2_div37", 32'(div_o[0]), 32'h1);
    step();
    chk("ch0_d2_ce38", 32'(ce_o[0]), 32'h1);
    chk("ch0_second_ready38", 32'(cfg_ready_o), 32'h1);

    // Pending ch1 write applied by sync; ch0 write at the sync edge stays pending
    step();
    step();
    cfg_req(2'd1, 8'd3);
    step();
    cfg_valid_i = 1'b0;
    chk("sync_ch1_pend41", 32'(cfg_ready_o), 32'h0);
    cfg_req(2'd0, 8'd6);
    sync_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
    sync_i = 1'b0;
    cfg_ch_i = 2'd1;
    #1;
    chk("sync_ch1_applied", 32'(cfg_ready_o), 32'h1);
    cfg_ch_i = 2'd0;
    #1;
    chk("sync_ch0_still_pend", 32'(cfg_ready_o), 32'h0);
    for (int k = 43; k <= 72; k++) begin
      step();
      e_ce = {exp_ce(cyc, 42, 7), exp_ce(cyc, 42, 5), exp_ce(cyc, 42, 3), exp_ce(cyc, 42, 6)};
      e_dv = {exp_dv(cyc, 42, 7), exp_dv(cyc, 42, 5), exp_dv(cyc, 42, 3), exp_dv(cyc, 42, 6)};
      chk("sync_ce", 32'(ce_o), 32'(e_ce));
      chk("sync_div", 32'(div_o), 32'(e_dv));
      if (((cyc - 42) % 15) == 0) chk("sync_coinc", 32'(ce_o[2:1]), 32'h3);
    end

    // ch3 -> 1: ce constantly high, waveform low
    cfg_req(2'd3, 8'd1);
    step();
    cfg_valid_i = 1'b0;
    repeat (4) step();
    chk("d1_apply_ce", 32'(ce_o[3]), 32'h1);
    for (int k = 78; k <= 81; k++) begin
      step();
      chk("d1_ce", 32'(ce_o[3]), 32'h1);
      chk("d1_div", 32'(div_o[3]), 32'h0);
    end

    // Acceptance on a terminal-count edge waits for the next one
    step();
    step();
    cfg_req(2'd1, 8'd7);
    step();
    cfg_valid_i = 1'b0;
    chk("tc_accept_ce84", 32'(ce_o[1]), 32'h1);
    chk("tc_accept_pend84", 32'(cfg_ready_o), 32'h0);
    step();
    chk("tc_accept_ce85", 32'(ce_o[1]), 32'h0);
    step();
    step();
    chk("tc_accept_ce87", 32'(ce_o[1]), 32'h1);
    chk("tc_accept_ready87", 32'(cfg_ready_o), 32'h1);

    // Reset mid-period with a pending ch1 write
    cfg_req(2'd1, 8'd5);
    step();
    cfg_valid_i = 1'b0;
    chk("mid_pend88", 32'(cfg_ready_o), 32'h0);
    chk("mid_div88", 32'(div_o[1]), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_ce", 32'(ce_o), 32'h0);
    chk("async_rst_div", 32'(div_o), 32'h0);
    chk("async_rst_active", 32'(active_o), 32'hF);
    chk("async_rst_ready", 32'(cfg_ready_o), 32'h1);
    $display("[TB] cyc %0d reset asserted mid-period", cyc);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_rst_ce", 32'(ce_o), 32'({4{exp_ce(cyc, 0, 4)}}));
      chk("post_rst_div", 32'(div_o), 32'({4{exp_dv(cyc, 0, 4)}}));
      chk("post_rst_active", 32'(active_o), 32'hF);
      chk("post_rst_ready", 32'(cfg_ready_o), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
